// File: rtl/cacheline_adapter_pkg.sv
// Shared types for the cacheline adapter: line geometry, FSM state encoding
// and the line-alignment helper used for DRAM addressing.
package cacheline_adapter_pkg;

  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned DEF_BEAT_W    = 64;
  localparam int unsigned DEF_LINE_W    = DEF_BURST_LEN * DEF_BEAT_W;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned OFFSET_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_BURST,
    ST_DONE
  } state_t;

  // DRAM bursts always start on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts single-cycle cacheline read/write requests into BURST_LEN-beat
// DRAM bursts and reassembles returning read beats into a full line.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned BEAT_W    = DEF_BEAT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             ufp_addr,
  input  logic                          ufp_read,
  input  logic                          ufp_write,
  input  logic [BURST_LEN*BEAT_W-1:0]   ufp_wdata,
  output logic [BURST_LEN*BEAT_W-1:0]   ufp_rdata,
  output logic                          ufp_resp,
  output logic [ADDR_W-1:0]             bmem_addr,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_W-1:0]             bmem_wdata,
  input  logic                          bmem_ready,
  input  logic [ADDR_W-1:0]             bmem_raddr,
  input  logic [BEAT_W-1:0]             bmem_rdata,
  input  logic                          bmem_rvalid
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_nxt;
  logic [ADDR_W-1:0]              addr_q;
  logic [BURST_LEN-1:0][BEAT_W-1:0] wline_q;
  logic [BURST_LEN-1:0][BEAT_W-1:0] rline_q;
  logic                           raddr_hit;

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign raddr_hit = bmem_rvalid && (bmem_raddr == addr_q);
  assign ufp_rdata = rline_q;

  // Single-process FSM; every bmem_* output is a register updated on the
  // transition that enters or leaves the requesting states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wline_q    <= '0;
      rline_q    <= '0;
      ufp_resp   <= 1'b0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_addr  <= '0;
      bmem_wdata <= '0;
    end else begin
      ufp_resp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (ufp_read) begin
            state     <= ST_RD_REQ;
            addr_q    <= line_align(ufp_addr);
            wline_q   <= ufp_wdata;
            bmem_read <= 1'b1;
            bmem_addr <= line_align(ufp_addr);
          end else if (ufp_write) begin
            state      <= ST_WR_BURST;
            addr_q     <= line_align(ufp_addr);
            wline_q    <= ufp_wdata;
            bmem_write <= 1'b1;
            bmem_addr  <= line_align(ufp_addr);
            bmem_wdata <= ufp_wdata[BEAT_W-1:0];
          end
        end

        ST_RD_REQ: begin
          if (bmem_ready) begin
            state     <= ST_RD_WAIT;
            bmem_read <= 1'b0;
            bmem_addr <= '0;
          end
        end

        // Beats from other requesters share the return bus; only our tag counts.
        ST_RD_WAIT: begin
          if (raddr_hit) begin
            rline_q[cnt] <= bmem_rdata;
            cnt          <= cnt_nxt;
            if (cnt == LAST_BEAT) begin
              state    <= ST_DONE;
              ufp_resp <= 1'b1;
            end
          end
        end

        ST_WR_BURST: begin
          if (bmem_ready) begin
            cnt <= cnt_nxt;
            if (cnt == LAST_BEAT) begin
              state      <= ST_DONE;
              ufp_resp   <= 1'b1;
              bmem_write <= 1'b0;
              bmem_addr  <= '0;
              bmem_wdata <= '0;
            end else begin
              bmem_wdata <= wline_q[cnt_nxt];
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus tasks queue expected
// responses/beats, a negedge monitor pops and compares them.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  localparam int BL = 4;
  localparam int BW = 64;
  localparam int LW = BL * BW;

  typedef struct {
    logic [LW-1:0] line;
    int            cyc;
  } resp_t;

  typedef struct {
    logic [BW-1:0] data;
    logic [31:0]   addr;
  } wbeat_t;

  typedef struct {
    logic          v;
    logic [31:0]   raddr;
    logic [BW-1:0] data;
  } slot_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ufp_addr;
  logic          ufp_read;
  logic          ufp_write;
  logic [LW-1:0] ufp_wdata;
  logic [LW-1:0] ufp_rdata;
  logic          ufp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [31:0]   bmem_raddr;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  resp_t       resp_q[$];
  wbeat_t      wbeat_q[$];
  logic [31:0] rreq_q[$];
  slot_t       slots[$];
  logic        rdy_pat[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic started = 1'b0;
  logic no_write = 1'b0;
  logic prev_resp = 1'b0;

  cacheline_adapter #(.BURST_LEN(BL), .BEAT_W(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ufp_addr   (ufp_addr),
    .ufp_read   (ufp_read),
    .ufp_write  (ufp_write),
    .ufp_wdata  (ufp_wdata),
    .ufp_rdata  (ufp_rdata),
    .ufp_resp   (ufp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic inv(input string name, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s at cycle %0d", name, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus per-cycle protocol invariants.
  always @(negedge clk) begin
    resp_t  r;
    wbeat_t w;
    logic [31:0] a;
    if (started) begin
      if (ufp_resp === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp at cycle %0d", cyc);
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", ufp_rdata, r.line);
          chk("resp_cycle", LW'(cyc), LW'(r.cyc));
        end
      end
      if (bmem_read === 1'b1 && bmem_ready === 1'b1) begin
        if (rreq_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read_req addr %h", bmem_addr);
        end else begin
          a = rreq_q.pop_front();
          chk("read_req_addr", LW'(bmem_addr), LW'(a));
        end
      end
      if (bmem_write === 1'b1 && bmem_ready === 1'b1) begin
        if (wbeat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write_beat data %h", bmem_wdata);
        end else begin
          w = wbeat_q.pop_front();
          chk("write_beat_data", LW'(bmem_wdata), LW'(w.data));
          chk("write_beat_addr", LW'(bmem_addr), LW'(w.addr));
        end
      end
      if (no_write) inv("write_during_read", bmem_write === 1'b0);
      inv("read_and_write", !(bmem_read === 1'b1 && bmem_write === 1'b1));
      inv("resp_back_to_back", !(ufp_resp === 1'b1 && prev_resp === 1'b1));
      if (bmem_read === 1'b1 || bmem_write === 1'b1)
        inv("addr_aligned", bmem_addr[4:0] === 5'd0);
      if (bmem_read !== 1'b1 && bmem_write !== 1'b1)
        inv("bmem_idle_zero", bmem_addr === 32'd0 && bmem_wdata === 64'd0);
      if (bmem_read === 1'b1)
        inv("wdata_zero_on_read", bmem_wdata === 64'd0);
      prev_resp = ufp_resp;
    end
  end

  task automatic add_slot(input logic v, input logic [31:0] raddr, input logic [BW-1:0] data);
    slot_t s;
    s.v = v; s.raddr = raddr; s.data = data;
    slots.push_back(s);
  endtask

  // Waits for the completion pulse, keeps the request up through the DONE
  // cycle and checks it was not taken as a new request.
  task automatic finish_req();
    int w;
    w = 0;
    while (ufp_resp !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (ufp_resp !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: got no ufp_resp expected one within 40 cycles");
    end
    @(posedge clk); #1;
    chk("no_accept_in_done", LW'({bmem_read, bmem_write}), '0);
    ufp_read  = 1'b0;
    ufp_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic wr_too, input int rd_delay,
                         input logic [LW-1:0] exp_line);
    logic [31:0] al;
    resp_t r;
    slot_t s;
    int t;
    int n;
    al = {addr[31:5], 5'd0};
    @(posedge clk); #1;
    ufp_addr  = addr;
    ufp_read  = 1'b1;
    ufp_write = wr_too;
    ufp_wdata = {4{64'hDEAD_BEEF_0BAD_F00D}};
    bmem_rvalid = 1'b1;
    bmem_raddr  = al;
    bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    t = cyc;
    n = slots.size();
    rreq_q.push_back(al);
    r.line = exp_line;
    r.cyc  = t + 2 + rd_delay + n;
    resp_q.push_back(r);
    for (int i = 0; i < rd_delay; i++) begin
      @(posedge clk); #1;
      bmem_ready = 1'b0;
    end
    @(posedge clk); #1;
    bmem_ready = 1'b1;
    while (slots.size() > 0) begin
      s = slots.pop_front();
      @(posedge clk); #1;
      bmem_ready  = 1'b0;
      bmem_rvalid = s.v;
      bmem_raddr  = s.raddr;
      bmem_rdata  = s.data;
    end
    @(posedge clk); #1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    finish_req();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LW-1:0] data,
                          input logic [LW-1:0] exp_rdata);
    logic [31:0] al;
    resp_t  r;
    wbeat_t w;
    logic   rv;
    int t;
    int ones;
    int last;
    al = {addr[31:5], 5'd0};
    ones = 0;
    last = -1;
    foreach (rdy_pat[i]) begin
      if (rdy_pat[i]) begin
        ones++;
        if (ones == BL) last = i;
      end
    end
    @(posedge clk); #1;
    ufp_addr  = addr;
    ufp_write = 1'b1;
    ufp_wdata = data;
    t = cyc;
    for (int k = 0; k < BL; k++) begin
      w.data = data[k*BW +: BW];
      w.addr = al;
      wbeat_q.push_back(w);
    end
    r.line = exp_rdata;
    r.cyc  = t + 2 + last;
    resp_q.push_back(r);
    while (rdy_pat.size() > 0) begin
      rv = rdy_pat.pop_front();
      @(posedge clk); #1;
      bmem_ready = rv;
    end
    @(posedge clk); #1;
    bmem_ready = 1'b0;
    finish_req();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ufp_resp"},   LW'(ufp_resp),   '0);
    chk({tag, "_bmem_read"},  LW'(bmem_read),  '0);
    chk({tag, "_bmem_write"}, LW'(bmem_write), '0);
    chk({tag, "_bmem_addr"},  LW'(bmem_addr),  '0);
    chk({tag, "_bmem_wdata"}, LW'(bmem_wdata), '0);
    chk({tag, "_ufp_rdata"},  ufp_rdata,       '0);
  endtask

  logic [LW-1:0] line1, line2, line4, line5, wline_a, wline_b;

  initial begin
    rst = 1'b1;
    ufp_addr = '0; ufp_read = 1'b0; ufp_write = 1'b0; ufp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1'b1;

    // Back-to-back minimum-latency read.
    line1 = 256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111;
    add_slot(1'b1, 32'h0000_1040, 64'h1111_1111_1111_1111);
    add_slot(1'b1, 32'h0000_1040, 64'h2222_2222_2222_2222);
    add_slot(1'b1, 32'h0000_1040, 64'h3333_3333_3333_3333);
    add_slot(1'b1, 32'h0000_1040, 64'h4444_4444_4444_4444);
    do_read(32'h0000_1040, 1'b0, 0, line1);

    // Unaligned read with foreign and gapped beats on the return bus.
    line2 = 256'hB3B3_0000_0000_0003_B2B2_0000_0000_0002_B1B1_0000_0000_0001_B0B0_0000_0000_0000;
    add_slot(1'b1, 32'h0000_2000, 64'hEEEE_0000_0000_0000);
    add_slot(1'b1, 32'h0000_1040, 64'hB0B0_0000_0000_0000);
    add_slot(1'b1, 32'h0000_2000, 64'hEEEE_0000_0000_0001);
    add_slot(1'b0, 32'h0000_1040, 64'hEEEE_0000_0000_0002);
    add_slot(1'b1, 32'h0000_1040, 64'hB1B1_0000_0000_0001);
    add_slot(1'b1, 32'h0000_1040, 64'hB2B2_0000_0000_0002);
    add_slot(1'b1, 32'h0000_2000, 64'hEEEE_0000_0000_0003);
    add_slot(1'b1, 32'h0000_1040, 64'hB3B3_0000_0000_0003);
    do_read(32'h0000_1047, 1'b0, 1, line2);

    // Minimum-latency write; read line must stay as it was.
    wline_a = 256'hA3A3_A3A3_0000_0003_A2A2_A2A2_0000_0002_A1A1_A1A1_0000_0001_A0A0_A0A0_0000_0000;
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
    do_write(32'h0000_8000, wline_a, line2);

    // Write with ready toggling 1,0,1,1,0,1.
    wline_b = 256'hDDDD_DDDD_DDDD_DDDD_CCCC_CCCC_CCCC_CCCC_BBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA;
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    do_write(32'hA000_0020, wline_b, line2);

    // Simultaneous read and write: read must win.
    line4 = 256'h0404_0404_0404_0404_0303_0303_0303_0303_0202_0202_0202_0202_0101_0101_0101_0101;
    no_write = 1'b1;
    add_slot(1'b1, 32'h0000_3000, 64'h0101_0101_0101_0101);
    add_slot(1'b1, 32'h0000_3000, 64'h0202_0202_0202_0202);
    add_slot(1'b1, 32'h0000_3000, 64'h0303_0303_0303_0303);
    add_slot(1'b1, 32'h0000_3000, 64'h0404_0404_0404_0404);
    do_read(32'h0000_3000, 1'b1, 0, line4);
    no_write = 1'b0;

    // Reset in the middle of a read burst.
    @(posedge clk); #1;
    ufp_addr = 32'h0000_5000; ufp_read = 1'b1;
    rreq_q.push_back(32'h0000_5000);
    @(posedge clk); #1;
    bmem_ready = 1'b1;
    @(posedge clk); #1;
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_5000; bmem_rdata = 64'h5050_0000_0000_0000;
    @(posedge clk); #1;
    bmem_rdata = 64'h5050_0000_0000_0001;
    @(posedge clk); #1;
    rst = 1'b1; ufp_read = 1'b0;
    bmem_rdata = 64'h5050_0000_0000_0002;
    @(posedge clk); #1;
    rst = 1'b0;
    bmem_rdata = 64'h5050_0000_0000_0003;
    chk_all_zero("midburst_reset");
    @(posedge clk); #1;
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    chk("post_reset_beat_ignored", ufp_rdata, '0);
    chk("post_reset_idle", LW'({bmem_read, bmem_write, ufp_resp}), '0);

    // Fresh read after the reset.
    line5 = 256'h6666_0000_0000_0003_6666_0000_0000_0002_6666_0000_0000_0001_6666_0000_0000_0000;
    add_slot(1'b1, 32'h0000_6000, 64'h6666_0000_0000_0000);
    add_slot(1'b1, 32'h0000_6000, 64'h6666_0000_0000_0001);
    add_slot(1'b1, 32'h0000_6000, 64'h6666_0000_0000_0002);
    add_slot(1'b1, 32'h0000_6000, 64'h6666_0000_0000_0003);
    do_read(32'h0000_6008, 1'b0, 0, line5);

    repeat (4) @(posedge clk);
    #1;
    chk("resp_queue_drained",  LW'(resp_q.size()),  '0);
    chk("wbeat_queue_drained", LW'(wbeat_q.size()), '0);
    chk("rreq_queue_drained",  LW'(rreq_q.size()),  '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 20000 cycles");
    $fatal(1, "simulation timeout");
  end

endmodule
